trap_seq: RTL and testbench
===========================

TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 The module SHALL have parameter XLEN, default 32, which sets the data/address width.
REQ-002 The module SHALL have port clk, input, width 1, the single clock; all state updates on the rising edge.
REQ-003 The module SHALL have port rst, input, width 1, the reset; synchronous and active-high.
REQ-004 The module SHALL have these event inputs:
- inst_end, input, 1, instruction boundary strobe; equals the core's write_pc.
- exception, input, 1, synchronous exception flag.
- exc_cause, input, XLEN, exception cause code.
- exc_pc, input, XLEN, PC of the faulting instruction.
- exc_tval, input, XLEN, trap value.
- mret, input, 1, MRET retiring, qualified by inst_end.
- next_pc, input, XLEN, PC of the next instruction.
REQ-005 The module SHALL have these interrupt and CSR inputs:
- irq_ext, irq_sw, irq_timer, input, 1 each, level interrupt lines.
- mie_en, input, 3, enables {MEIE, MTIE, MSIE}.
- mstatus_mie, mstatus_mpie, input, 1 each, current MSTATUS bits.
- mtvec, input, XLEN, MTVEC register.
- mepc, input, XLEN, MEPC register.
REQ-006 The module SHALL have these outputs:
- stall, output, 1, holds the core in fetch.
- mepc_we, mcause_we, mtval_we, mstatus_we, output, 1 each, CSR write strobes.
- mepc_d, mcause_d, mtval_d, output, XLEN each, CSR write data.
- mie_d, mpie_d, output, 1 each, MSTATUS write data.
- redirect_valid, output, 1, PC redirect request.
- redirect_pc, output, XLEN, redirect target.
- redirect_ready, input, 1, core accepts the redirect.
- mip, output, 3, pending bits {MEIP, MTIP, MSIP}.

Function
REQ-007 The FSM SHALL have states IDLE, ENTRY, RET, REDIR.
REQ-008 The module SHALL sample mip as registered {irq_ext, irq_timer, irq_sw}, with 1-cycle latency in every state.
REQ-009 In IDLE with inst_end=1, the module SHALL select an event in this priority order:
- exception;
- interrupt, if mstatus_mie=1 and (mip & mie_en)!=0;
- mret;
- otherwise no action.
REQ-010 Interrupt priority SHALL be MEI (code 11) > MSI (3) > MTI (7); mcause_d SHALL have bit XLEN-1 set for interrupts and clear for exceptions.
REQ-011 On selecting a trap, the module SHALL latch cause, epc, tval and the vector target, then go to ENTRY.
- epc: exc_pc for an exception, next_pc for an interrupt.
- tval: exc_tval for an exception, 0 for an interrupt.
REQ-012 ENTRY SHALL last exactly 1 cycle and then go to REDIR. It SHALL assert mepc_we, mcause_we, mtval_we and mstatus_we, with mie_d=0 and mpie_d=mstatus_mie.
REQ-013 The vector target SHALL be {mtvec[XLEN-1:2],2'b00} if mtvec[1:0]!=1 or the trap is an exception; otherwise base+4*code, computed modulo 2^XLEN.
REQ-014 On selecting mret, the module SHALL latch mepc as the target and go to RET.
REQ-015 RET SHALL last exactly 1 cycle and then go to REDIR. It SHALL assert mstatus_we only, with mie_d=mstatus_mpie and mpie_d=1.
REQ-016 REDIR SHALL hold redirect_valid=1 with a stable redirect_pc until the cycle redirect_ready=1, then return to IDLE.
REQ-017 stall SHALL be 1 in ENTRY, RET and REDIR, and combinationally 1 in the IDLE cycle an event is selected.
REQ-018 Events presented outside IDLE SHALL be ignored and not queued; the core is stalled in those states.
REQ-019 An exception and mret in the same cycle SHALL take the exception; mret SHALL cause no MSTATUS write.
REQ-020 All write strobes SHALL be 0 outside ENTRY/RET and SHALL pulse for exactly 1 cycle.

Reset
REQ-021 With rst=1 at a clock edge, the module SHALL go to IDLE and clear all latched registers and mip. All outputs SHALL be 0 the next cycle.
REQ-022 Reset asserted during ENTRY, RET or REDIR SHALL abort the sequence with no further strobes and redirect_valid=0.

Structure
REQ-023 The cause codes, interrupt bit position, mtvec mode encodings and the FSM state enum SHALL reside in the shared CSR package.
REQ-024 The interrupt priority encoder SHALL be the sub-module irq_prio: inputs pending&enable, outputs valid and code.

Verification
REQ-025 Exception: exception=1, exc_cause=2, exc_pc=0x100 at inst_end -> ENTRY writes mcause=2, mepc=0x100, mie_d=0; redirect_pc=mtvec base 2 cycles later.
REQ-026 Vectored interrupt: mtvec=0x1001, mstatus_mie=1, irq_timer=1, mie_en=3'b010 -> mcause=0x80000007, redirect_pc=0x101C, mepc=next_pc.
REQ-027 mret: mepc=0x200, mstatus_mpie=1 -> RET writes mie_d=1, mpie_d=1; redirect_pc=0x200.
REQ-028 Simultaneous irq_ext, irq_sw and exception -> exception is taken; with the exception removed, code 11 is taken before code 3.
REQ-029 Backpressure: redirect_ready held 0 for 5 cycles -> redirect_valid, redirect_pc and stall are stable; exit to IDLE the cycle after ready=1.
REQ-030 Reset in REDIR: rst=1 -> next cycle redirect_valid=0, stall=0, state IDLE, no CSR strobe.

Source files
------------

// File: rtl/trap_seq_pkg.sv
// Shared CSR/trap definitions: FSM states, event kinds, cause codes,
// mip bit positions and mtvec mode encodings.
package trap_seq_pkg;

  // Trap sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_RET   = 2'd2,
    ST_REDIR = 2'd3
  } trap_state_e;

  // Event chosen at an instruction boundary
  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_EXC  = 2'd1,
    EV_IRQ  = 2'd2,
    EV_MRET = 2'd3
  } trap_event_e;

  // Width of an interrupt cause code (largest code is 11)
  localparam int CODE_W = 5;

  // Machine-level interrupt cause codes
  localparam logic [CODE_W-1:0] CAUSE_MSI = 5'd3;
  localparam logic [CODE_W-1:0] CAUSE_MTI = 5'd7;
  localparam logic [CODE_W-1:0] CAUSE_MEI = 5'd11;

  // Bit positions inside mip / mie_en: {MEI, MTI, MSI}
  localparam int MIP_MSI_BIT = 0;
  localparam int MIP_MTI_BIT = 1;
  localparam int MIP_MEI_BIT = 2;

  // mtvec[1:0] mode encodings
  localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_VECTORED = 2'd1;

  // The interrupt flag of mcause sits in the top bit of the register
  function automatic int irq_flag_pos(input int xlen);
    return xlen - 1;
  endfunction

endpackage : trap_seq_pkg

// File: rtl/trap_seq_irq_prio.sv
// Fixed-priority encoder for machine interrupts: MEI > MSI > MTI.
module irq_prio
  import trap_seq_pkg::*;
(
  input  logic [2:0]        pend_en,
  output logic              valid,
  output logic [CODE_W-1:0] code
);

  // Pick the highest-priority pending-and-enabled interrupt
  always_comb begin
    valid = |pend_en;
    code  = '0;
    if (pend_en[MIP_MEI_BIT]) begin
      code = CAUSE_MEI;
    end else if (pend_en[MIP_MSI_BIT]) begin
      code = CAUSE_MSI;
    end else if (pend_en[MIP_MTI_BIT]) begin
      code = CAUSE_MTI;
    end
  end

endmodule : irq_prio

// File: rtl/trap_seq.sv
// Machine-mode trap sequencer: at an instruction boundary it selects an
// exception, interrupt or mret, performs the CSR update cycle and then
// requests a PC redirect, holding the core stalled until it is accepted.
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inst_end,
  input  logic            exception,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic [XLEN-1:0] exc_tval,
  input  logic            mret,
  input  logic [XLEN-1:0] next_pc,
  input  logic            irq_ext,
  input  logic            irq_sw,
  input  logic            irq_timer,
  input  logic [2:0]      mie_en,
  input  logic            mstatus_mie,
  input  logic            mstatus_mpie,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            stall,
  output logic            mepc_we,
  output logic            mcause_we,
  output logic            mtval_we,
  output logic            mstatus_we,
  output logic [XLEN-1:0] mepc_d,
  output logic [XLEN-1:0] mcause_d,
  output logic [XLEN-1:0] mtval_d,
  output logic            mie_d,
  output logic            mpie_d,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  input  logic            redirect_ready,
  output logic [2:0]      mip
);

  localparam int IRQ_POS = irq_flag_pos(XLEN);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [2:0]      mip_q, mip_d;

  logic              irq_valid;
  logic [CODE_W-1:0] irq_code;
  logic [2:0]        irq_pend_en;
  logic              irq_take;
  trap_event_e       event_sel;
  logic [XLEN-1:0]   vec_base;
  logic [XLEN-1:0]   vec_target;
  logic [XLEN-1:0]   irq_cause;
  logic [XLEN-1:0]   exc_cause_clean;

  // Interrupts are judged on the registered pending lines only
  assign irq_pend_en = mip_q & mie_en;
  assign mip         = mip_q;

  irq_prio u_irq_prio (
    .pend_en (irq_pend_en),
    .valid   (irq_valid),
    .code    (irq_code)
  );

  // Event selection and trap vector / cause formation
  always_comb begin
    irq_take = mstatus_mie & irq_valid;

    event_sel = EV_NONE;
    if ((state_q == ST_IDLE) && inst_end) begin
      if (exception) begin
        event_sel = EV_EXC;
      end else if (irq_take) begin
        event_sel = EV_IRQ;
      end else if (mret) begin
        event_sel = EV_MRET;
      end
    end

    // Vector offset is 4*code; the add wraps modulo 2^XLEN by width
    vec_base   = {mtvec[XLEN-1:2], 2'b00};
    vec_target = vec_base + {{(XLEN-CODE_W-2){1'b0}}, irq_code, 2'b00};

    irq_cause                 = '0;
    irq_cause[CODE_W-1:0]     = irq_code;
    irq_cause[IRQ_POS]        = 1'b1;

    // Exceptions never carry the interrupt flag, whatever the core sends
    exc_cause_clean           = exc_cause;
    exc_cause_clean[IRQ_POS]  = 1'b0;
  end

  // Next-state, latched trap data and all outputs
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    epc_d          = epc_q;
    tval_d         = tval_q;
    target_d       = target_q;
    mip_d          = {irq_ext, irq_timer, irq_sw};

    stall          = 1'b0;
    mepc_we        = 1'b0;
    mcause_we      = 1'b0;
    mtval_we       = 1'b0;
    mstatus_we     = 1'b0;
    mepc_d         = '0;
    mcause_d       = '0;
    mtval_d        = '0;
    mie_d          = 1'b0;
    mpie_d         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    case (state_q)
      ST_IDLE: begin
        case (event_sel)
          EV_EXC: begin
            stall    = 1'b1;
            cause_d  = exc_cause_clean;
            epc_d    = exc_pc;
            tval_d   = exc_tval;
            target_d = vec_base;
            state_d  = ST_ENTRY;
          end
          EV_IRQ: begin
            stall    = 1'b1;
            cause_d  = irq_cause;
            epc_d    = next_pc;
            tval_d   = '0;
            target_d = (mtvec[1:0] == MTVEC_VECTORED) ? vec_target : vec_base;
            state_d  = ST_ENTRY;
          end
          EV_MRET: begin
            stall    = 1'b1;
            target_d = mepc;
            state_d  = ST_RET;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end

      ST_ENTRY: begin
        stall      = 1'b1;
        mepc_we    = 1'b1;
        mcause_we  = 1'b1;
        mtval_we   = 1'b1;
        mstatus_we = 1'b1;
        mepc_d     = epc_q;
        mcause_d   = cause_q;
        mtval_d    = tval_q;
        mie_d      = 1'b0;
        mpie_d     = mstatus_mie;
        state_d    = ST_REDIR;
      end

      ST_RET: begin
        stall      = 1'b1;
        mstatus_we = 1'b1;
        mie_d      = mstatus_mpie;
        mpie_d     = 1'b1;
        state_d    = ST_REDIR;
      end

      ST_REDIR: begin
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-data registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cause_q  <= '0;
      epc_q    <= '0;
      tval_q   <= '0;
      target_q <= '0;
      mip_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      epc_q    <= epc_d;
      tval_q   <= tval_d;
      target_q <= target_d;
      mip_q    <= mip_d;
    end
  end

endmodule : trap_seq

// File: tb/tb_trap_seq.sv
// Directed bench for trap_seq: a cycle-level behavioural model checked on
// every negative edge, plus literal expectations for the key scenarios.
module tb_trap_seq;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_end, exception, mret;
  logic [XLEN-1:0] exc_cause, exc_pc, exc_tval, next_pc;
  logic            irq_ext, irq_sw, irq_timer;
  logic [2:0]      mie_en;
  logic            mstatus_mie, mstatus_mpie;
  logic [XLEN-1:0] mtvec, mepc;
  logic            stall;
  logic            mepc_we, mcause_we, mtval_we, mstatus_we;
  logic [XLEN-1:0] mepc_d, mcause_d, mtval_d;
  logic            mie_d, mpie_d;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;
  logic [2:0]      mip;

  always #5 clk = ~clk;

  trap_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .inst_end(inst_end), .exception(exception),
    .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret(mret), .next_pc(next_pc), .irq_ext(irq_ext), .irq_sw(irq_sw),
    .irq_timer(irq_timer), .mie_en(mie_en), .mstatus_mie(mstatus_mie),
    .mstatus_mpie(mstatus_mpie), .mtvec(mtvec), .mepc(mepc),
    .stall(stall), .mepc_we(mepc_we), .mcause_we(mcause_we),
    .mtval_we(mtval_we), .mstatus_we(mstatus_we), .mepc_d(mepc_d),
    .mcause_d(mcause_d), .mtval_d(mtval_d), .mie_d(mie_d), .mpie_d(mpie_d),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .mip(mip)
  );

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 = waiting for an event, 1 = CSR update cycle, 2 = redirect
  int              m_phase = 0;
  bit              m_is_mret = 1'b0;
  logic [XLEN-1:0] m_cause = '0, m_epc = '0, m_tval = '0, m_target = '0;
  logic [2:0]      m_mip = '0;   // {MEI, MTI, MSI} as seen one cycle ago

  // priority list: code and its bit in {MEI, MTI, MSI}
  int prio_code [3] = '{11, 3, 7};
  int prio_bit  [3] = '{2, 0, 1};

  function automatic bit irq_pick(input logic [2:0] pend, output int code);
    code = 0;
    for (int k = 0; k < 3; k++) begin
      if (pend[prio_bit[k]]) begin
        code = prio_code[k];
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    int  code;
    bit  found;
    logic [XLEN-1:0] base;
    if (rst) begin
      m_phase = 0; m_is_mret = 0; m_mip = '0;
      m_cause = '0; m_epc = '0; m_tval = '0; m_target = '0;
    end else begin
      base = mtvec & ~32'h3;
      if (m_phase == 0) begin
        found = irq_pick(m_mip & mie_en, code);
        if (inst_end && exception) begin
          m_is_mret = 0; m_phase = 1;
          m_cause = exc_cause & 32'h7FFF_FFFF;
          m_epc = exc_pc; m_tval = exc_tval; m_target = base;
          $display("txn exception cause=%0d epc=0x%0h target=0x%0h", m_cause, m_epc, m_target);
        end else if (inst_end && mstatus_mie && found) begin
          m_is_mret = 0; m_phase = 1;
          m_cause = 32'h8000_0000 + 32'(code);
          m_epc = next_pc; m_tval = '0;
          m_target = (mtvec[1:0] == 2'd1) ? base + 32'(4 * code) : base;
          $display("txn interrupt code=%0d epc=0x%0h target=0x%0h", code, m_epc, m_target);
        end else if (inst_end && mret) begin
          m_is_mret = 1; m_phase = 1; m_target = mepc;
          $display("txn mret target=0x%0h", m_target);
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (redirect_ready) begin
        m_phase = 0;
      end
      m_mip = {irq_ext, irq_timer, irq_sw};
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    bit wr, trap_wr, any_ev;
    if (chk_en) begin
      wr      = (m_phase == 1);
      trap_wr = wr && !m_is_mret;
      any_ev  = inst_end && (exception || mret ||
                (mstatus_mie && ((m_mip & mie_en) != 3'b000)));
      check("stall", stall, (m_phase != 0) || any_ev);
      check("mepc_we", mepc_we, trap_wr);
      check("mcause_we", mcause_we, trap_wr);
      check("mtval_we", mtval_we, trap_wr);
      check("mstatus_we", mstatus_we, wr);
      check("mepc_d", mepc_d, trap_wr ? m_epc : '0);
      check("mcause_d", mcause_d, trap_wr ? m_cause : '0);
      check("mtval_d", mtval_d, trap_wr ? m_tval : '0);
      check("mie_d", mie_d, wr && m_is_mret && mstatus_mpie);
      check("mpie_d", mpie_d, wr && (m_is_mret || mstatus_mie));
      check("redirect_valid", redirect_valid, m_phase == 2);
      check("redirect_pc", redirect_pc, (m_phase == 2) ? m_target : '0);
      check("mip", mip, m_mip);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic quiet();
    inst_end = 0; exception = 0; mret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1; quiet(); exc_cause = 0; exc_pc = 0; exc_tval = 0; next_pc = 0;
    irq_ext = 1; irq_sw = 0; irq_timer = 0; mie_en = 3'b000;
    mstatus_mie = 0; mstatus_mpie = 0; mtvec = 0; mepc = 0; redirect_ready = 0;
    cyc(); cyc();
    chk_en = 1;
    neg();
    check("lit_rst_mip", mip, 0);
    check("lit_rst_redirect_valid", redirect_valid, 0);
    cyc(); rst = 0; irq_ext = 0;
    cyc();

    // exception into direct vector
    cyc(); mtvec = 32'h400; exception = 1; exc_cause = 2; exc_pc = 32'h100;
    exc_tval = 32'h55; inst_end = 1;
    neg(); check("lit_exc_stall", stall, 1);
    cyc(); quiet();
    neg(); check("lit_exc_mcause", mcause_d, 2); check("lit_exc_mepc", mepc_d, 32'h100);
    check("lit_exc_mie_d", mie_d, 0); check("lit_exc_mcause_we", mcause_we, 1);
    cyc(); redirect_ready = 1;
    neg(); check("lit_exc_redirect_pc", redirect_pc, 32'h400);
    cyc(); redirect_ready = 0;
    neg(); check("lit_exc_idle_stall", stall, 0);

    // vectored timer interrupt
    cyc(); mtvec = 32'h1001; mstatus_mie = 1; irq_timer = 1; mie_en = 3'b010;
    next_pc = 32'h344;
    cyc(); inst_end = 1;
    neg(); check("lit_irq_stall", stall, 1);
    cyc(); quiet(); irq_timer = 0;
    neg(); check("lit_irq_mcause", mcause_d, 32'h8000_0007);
    check("lit_irq_mepc", mepc_d, 32'h344); check("lit_irq_mpie_d", mpie_d, 1);
    cyc(); redirect_ready = 1;
    neg(); check("lit_irq_redirect_pc", redirect_pc, 32'h101C);
    cyc(); redirect_ready = 0;

    // mret
    cyc(); mstatus_mie = 0; mstatus_mpie = 1; mepc = 32'h200; mret = 1; inst_end = 1;
    cyc(); quiet();
    neg(); check("lit_mret_mstatus_we", mstatus_we, 1); check("lit_mret_mepc_we", mepc_we, 0);
    check("lit_mret_mie_d", mie_d, 1); check("lit_mret_mpie_d", mpie_d, 1);
    cyc(); redirect_ready = 1;
    neg(); check("lit_mret_redirect_pc", redirect_pc, 32'h200);
    cyc(); redirect_ready = 0;

    // exception beats interrupts; then MEI before MSI
    cyc(); mtvec = 32'h1001; mstatus_mie = 1; mie_en = 3'b111; irq_ext = 1; irq_sw = 1;
    cyc(); exception = 1; exc_cause = 5; exc_pc = 32'h80; inst_end = 1;
    cyc(); quiet();
    neg(); check("lit_prio_exc_mcause", mcause_d, 5);
    cyc(); redirect_ready = 1;
    neg(); check("lit_prio_exc_pc", redirect_pc, 32'h1000);
    cyc(); redirect_ready = 0; inst_end = 1;
    cyc(); quiet();
    neg(); check("lit_prio_mei", mcause_d, 32'h8000_000B);
    cyc(); redirect_ready = 1;
    neg(); check("lit_prio_mei_pc", redirect_pc, 32'h102C);
    cyc(); redirect_ready = 0; irq_ext = 0;
    cyc(); inst_end = 1;
    cyc(); quiet();
    neg(); check("lit_prio_msi", mcause_d, 32'h8000_0003);
    cyc(); redirect_ready = 1;
    neg(); check("lit_prio_msi_pc", redirect_pc, 32'h100C);
    cyc(); redirect_ready = 0; irq_sw = 0;

    // backpressure, with events presented while busy
    cyc(); mtvec = 32'h800; mstatus_mie = 0; exception = 1; exc_cause = 4; inst_end = 1;
    cyc(); quiet();
    cyc(); exception = 1; inst_end = 1;
    for (int i = 0; i < 5; i++) begin
      neg();
      check("lit_bp_valid", redirect_valid, 1);
      check("lit_bp_pc", redirect_pc, 32'h800);
      check("lit_bp_stall", stall, 1);
      cyc();
      if (i == 2) quiet();
    end
    redirect_ready = 1;
    neg(); check("lit_bp_last_valid", redirect_valid, 1);
    cyc(); redirect_ready = 0;
    neg(); check("lit_bp_exit_valid", redirect_valid, 0); check("lit_bp_exit_stall", stall, 0);

    // exception and mret together
    cyc(); mstatus_mie = 1; mstatus_mpie = 0; mtvec = 32'h400; mepc = 32'h999;
    exception = 1; mret = 1; exc_cause = 1; exc_pc = 32'h40; inst_end = 1;
    cyc(); quiet();
    neg(); check("lit_excmret_mcause", mcause_d, 1); check("lit_excmret_mepc_we", mepc_we, 1);
    check("lit_excmret_mie_d", mie_d, 0);
    cyc(); redirect_ready = 1;
    neg(); check("lit_excmret_pc", redirect_pc, 32'h400);
    cyc(); redirect_ready = 0;

    // reset while in REDIR
    cyc(); exception = 1; exc_cause = 7; inst_end = 1;
    cyc(); quiet();
    cyc(); rst = 1;
    neg(); check("lit_rstredir_before", redirect_valid, 1);
    cyc(); rst = 0;
    neg(); check("lit_rstredir_valid", redirect_valid, 0); check("lit_rstredir_stall", stall, 0);
    check("lit_rstredir_we", mstatus_we, 0);

    // reset while in ENTRY
    cyc(); exception = 1; exc_cause = 6; inst_end = 1;
    cyc(); quiet(); rst = 1;
    cyc(); rst = 0;
    neg(); check("lit_rstentry_we", mepc_we, 0);
    cyc();
    neg(); check("lit_rstentry_valid", redirect_valid, 0);

    // pending interrupt masked by mstatus_mie=0
    cyc(); mstatus_mie = 0; mie_en = 3'b111; irq_ext = 1;
    cyc(); inst_end = 1;
    neg(); check("lit_masked_stall", stall, 0);
    cyc(); quiet(); irq_ext = 0;
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_trap_seq
